// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store responder with lane steering, extension and bus timeout
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [5:0]  op_code,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err,
    output logic        ctrl_err,
    output logic        bus_err,
    output logic [31:0] bad_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [5:0]  op_q;
    logic [31:0] addr_q;

    logic        is_load;
    logic        is_store;
    logic        size_byte;
    logic        size_half;
    logic        legal;
    logic        ctrl_bad;
    logic        misaligned;
    logic        start;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size_byte = 1'b0;
        size_half = 1'b0;
        case (op_code)
            OP_LB, OP_LBU: begin is_load = 1'b1;  size_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load = 1'b1;  size_half = 1'b1; end
            OP_LW:         is_load = 1'b1;
            OP_SB:         begin is_store = 1'b1; size_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; size_half = 1'b1; end
            OP_SW:         is_store = 1'b1;
            default:       ;
        endcase
    end

    // The opcode class must agree with whichever single enable is raised.
    assign legal      = (mem_read_en & ~mem_write_en & is_load) |
                        (mem_write_en & ~mem_read_en & is_store);
    assign ctrl_bad   = (mem_read_en | mem_write_en) & ~legal;
    assign misaligned = size_half ? addr[0] : (~size_byte & (addr[1:0] != 2'b00));
    assign start      = legal & ~misaligned;
    assign stall      = (state == ST_WAIT) | ((state == ST_IDLE) & start);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        if (is_load) begin
            st_wdata = '0;
        end else if (size_byte) begin
            st_be    = 4'b0001 << addr[1:0];
            st_wdata = {4{store_data[7:0]}};
        end else if (size_half) begin
            st_be    = addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{store_data[15:0]}};
        end
    end

    function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'b0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            addr_err   <= 1'b0;
            ctrl_err   <= 1'b0;
            bus_err    <= 1'b0;
            bad_addr   <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
        end else begin
            load_valid <= 1'b0;
            addr_err   <= 1'b0;
            ctrl_err   <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        op_q      <= op_code;
                        addr_q    <= addr;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write_en;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= st_be;
                        bus_wdata <= st_wdata;
                        state     <= ST_WAIT;
                    end else if (ctrl_bad) begin
                        ctrl_err <= 1'b1;
                    end else if (legal) begin
                        addr_err <= 1'b1;
                        bad_addr <= addr;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack || cnt == CNT_LAST) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                        state     <= ST_RESP;
                        if (bus_ack) begin
                            if (!bus_we) begin
                                load_data  <= extend_load(op_q, addr_q[1:0], bus_rdata);
                                load_valid <= 1'b1;
                            end
                        end else begin
                            bus_err   <= 1'b1;
                            bad_addr  <= addr_q;
                            load_data <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench with a per-cycle expected-trace model for mem_access_unit
module tb_mem_access_unit;
    localparam int TO = 4;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0;
    logic [5:0]  op_code = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic        stall, load_valid, addr_err, ctrl_err, bus_err;
    logic [31:0] load_data, bad_addr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .op_code(op_code), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .addr_err(addr_err),
        .ctrl_err(ctrl_err), .bus_err(bus_err), .bad_addr(bad_addr), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic        stall, bus_req, bus_we;
        logic [31:0] bus_addr;
        logic [3:0]  bus_be;
        logic [31:0] bus_wdata;
        logic        load_valid, chk_ld;
        logic [31:0] load_data;
        logic        addr_err, ctrl_err, bus_err;
        logic [31:0] bad_addr;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_bad = '0;

    int          mon_stall = 0, mon_req = 0, mon_ctrl = 0, mon_berr = 0;
    logic [31:0] mon_ld = '0, mon_ba = '0, mon_wd = '0, mon_bad = '0;
    logic [3:0]  mon_be = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.bad_addr = model_bad;
        return e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", stall, e.stall);
            chk("bus_req", bus_req, e.bus_req);
            chk("bus_we", bus_we, e.bus_we);
            chk("bus_addr", bus_addr, e.bus_addr);
            chk("bus_be", bus_be, e.bus_be);
            if (e.bus_we) chk("bus_wdata", bus_wdata, e.bus_wdata);
            chk("load_valid", load_valid, e.load_valid);
            if (e.chk_ld) chk("load_data", load_data, e.load_data);
            chk("addr_err", addr_err, e.addr_err);
            chk("ctrl_err", ctrl_err, e.ctrl_err);
            chk("bus_err", bus_err, e.bus_err);
            chk("bad_addr", bad_addr, e.bad_addr);
        end
        if (stall) mon_stall <= mon_stall + 1;
        if (bus_req) begin
            mon_req <= mon_req + 1;
            mon_be  <= bus_be;
            mon_wd  <= bus_wdata;
            mon_ba  <= bus_addr;
        end
        if (load_valid || bus_err) mon_ld <= load_data;
        if (addr_err || bus_err) mon_bad <= bad_addr;
        if (ctrl_err) mon_ctrl <= mon_ctrl + 1;
        if (bus_err) mon_berr <= mon_berr + 1;
    end

    task automatic step(input logic rd, input logic wr, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic ack, input logic [31:0] word, input exp_t e);
        mem_read_en  = rd;
        mem_write_en = wr;
        op_code      = op;
        addr         = a;
        store_data   = d;
        bus_ack      = ack;
        bus_rdata    = word;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ack_dly: WAIT cycle index carrying bus_ack, or -1 for no ack at all.
    task automatic run_access(input logic rd, input logic wr, input logic [5:0] op,
                              input logic [31:0] a, input logic [31:0] d,
                              input int ack_dly, input logic [31:0] word);
        bit          is_ld, is_st, legal, mis;
        int          nb, nwait, lane;
        logic [31:0] mask, ld_val;
        exp_t        e;
        is_ld = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_st = op inside {OP_SB, OP_SH, OP_SW};
        nb    = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
        lane  = int'(a[1:0]);
        legal = (rd != wr) && (rd ? is_ld : is_st);
        mis   = (lane % nb) != 0;
        e = idle_exp();
        if (!legal || mis) begin
            step(rd, wr, op, a, d, 1'b0, word, e);
            if (legal) model_bad = a;
            e = idle_exp();
            e.ctrl_err = !legal && (rd || wr);
            e.addr_err = legal && mis;
            step(1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0, e);
            return;
        end
        e.stall = 1'b1;
        step(rd, wr, op, a, d, 1'b0, ~word, e);
        nwait = (ack_dly >= 0) ? ack_dly + 1 : TO;
        for (int i = 0; i < nwait; i++) begin
            e = idle_exp();
            e.stall     = 1'b1;
            e.bus_req   = 1'b1;
            e.bus_we    = wr;
            e.bus_addr  = a & ~32'h3;
            e.bus_be    = is_ld ? 4'hF : 4'(((1 << nb) - 1) << lane);
            e.bus_wdata = (nb == 1) ? {4{d[7:0]}} : (nb == 2) ? {2{d[15:0]}} : d;
            step(rd, wr, op, a, d, i == ack_dly, (i == ack_dly) ? word : ~word, e);
        end
        mask   = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        ld_val = (word >> (8 * lane)) & mask;
        if ((op == OP_LB || op == OP_LH) && ld_val[8 * nb - 1]) ld_val = ld_val | ~mask;
        if (ack_dly < 0) model_bad = a;
        e = idle_exp();
        e.load_valid = is_ld && ack_dly >= 0;
        e.bus_err    = ack_dly < 0;
        e.chk_ld     = e.load_valid || e.bus_err;
        e.load_data  = e.bus_err ? 32'h0 : ld_val;
        step(rd, wr, op, a, d, 1'b0, word, e);
        e = idle_exp();
        step(1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0, e);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int s0, r0, c0, b0;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_bad_addr", bad_addr, 0);
        chk("rst_errs", {addr_err, ctrl_err, bus_err}, 0);
        chk("rst_bus_fields", bus_addr | bus_wdata | bus_be | bus_we, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        s0 = mon_stall;
        run_access(1, 0, OP_LW, 32'h100, 0, 0, 32'hDEADBEEF);
        chk("lw_stall_cycles", mon_stall - s0, 2);
        chk("lw_data", mon_ld, 32'hDEADBEEF);
        run_access(1, 0, OP_LB, 32'h103, 0, 1, 32'h80FF_FF7F);
        chk("lb_data", mon_ld, 32'hFFFFFF80);
        run_access(1, 0, OP_LBU, 32'h103, 0, 0, 32'h80FF_FF7F);
        chk("lbu_data", mon_ld, 32'h00000080);
        run_access(1, 0, OP_LH, 32'h102, 0, 2, 32'h8001_1234);
        chk("lh_data", mon_ld, 32'hFFFF8001);
        run_access(1, 0, OP_LHU, 32'h100, 0, 0, 32'h8001_F00D);
        chk("lhu_data", mon_ld, 32'h0000F00D);
        run_access(1, 0, OP_LB, 32'h101, 0, 0, 32'h0000_7F00);
        run_access(1, 0, OP_LW, 32'h104, 0, TO - 1, 32'h0BAD_F00D);
        chk("lw_late_ack", mon_ld, 32'h0BADF00D);

        run_access(0, 1, OP_SH, 32'h202, 32'h1234ABCD, 1, 0);
        chk("sh_be", mon_be, 4'b1100);
        chk("sh_wdata", mon_wd, 32'hABCDABCD);
        chk("sh_addr", mon_ba, 32'h200);
        for (int i = 0; i < 4; i++) run_access(0, 1, OP_SB, 32'h300 + i, 32'h0000_00A5 + i, i % 2, 0);
        run_access(0, 1, OP_SH, 32'h200, 32'h5555_6789, 0, 0);
        run_access(0, 1, OP_SW, 32'h208, 32'hCAFEBABE, 0, 0);

        r0 = mon_req;
        run_access(1, 0, OP_LW, 32'h101, 0, 0, 0);
        chk("lw_mis_bad_addr", mon_bad, 32'h101);
        chk("lw_mis_no_req", mon_req - r0, 0);
        run_access(1, 0, OP_LH, 32'h103, 0, 0, 0);
        run_access(0, 1, OP_SH, 32'h201, 32'h1, 0, 0);
        run_access(0, 1, OP_SW, 32'h20A, 32'h1, 0, 0);
        c0 = mon_ctrl;
        r0 = mon_req;
        run_access(1, 1, OP_LW, 32'h100, 0, 0, 0);
        chk("both_en_ctrl_err", mon_ctrl - c0, 1);
        chk("both_en_no_req", mon_req - r0, 0);
        run_access(0, 1, OP_LW, 32'h100, 0, 0, 0);
        run_access(1, 0, OP_SW, 32'h100, 0, 0, 0);
        run_access(1, 0, 6'h00, 32'h100, 0, 0, 0);
        run_access(0, 0, OP_LW, 32'h100, 0, 0, 0);

        r0 = mon_req;
        b0 = mon_berr;
        run_access(1, 0, OP_LW, 32'h400, 0, -1, 32'h1111_2222);
        chk("to_req_cycles", mon_req - r0, TO);
        chk("to_bus_err", mon_berr - b0, 1);
        chk("to_load_data", mon_ld, 0);
        chk("to_bad_addr", mon_bad, 32'h400);
        run_access(0, 1, OP_SB, 32'h502, 32'h77, -1, 0);

        mem_read_en = 1'b1;
        op_code     = OP_LW;
        addr        = 32'h300;
        @(posedge clk);
        #1 chk("pre_rst_req", bus_req, 1);
        #1 rst_n = 1'b0;
        mem_read_en = 1'b0;
        #1;
        chk("rst_mid_req", bus_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_be", bus_be, 0);
        chk("rst_mid_bad_addr", bad_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_bad = '0;
        run_access(1, 0, OP_LW, 32'h300, 0, 0, 32'h600D_600D);
        chk("post_rst_lw", mon_ld, 32'h600D600D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
